// File: rtl/control_panel_io.sv
// Control panel I/O stage: applies the requested control word either as a
// registered pass-through (modo = 0) or one word per debounced press of the
// step button (modo = 1), with a one-cycle write-enable pulse per step.
module control_panel_io #(
    parameter int N_REG      = 8,
    parameter int MUX_W      = 7,
    parameter int CODE_W     = 3,
    parameter int DEB_CYCLES = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              modo,
    input  logic              passo_e,
    input  logic [N_REG-1:0]  escreve_e,
    input  logic [MUX_W-1:0]  seleciona_e,
    input  logic              RD_e,
    input  logic              OE_e,
    input  logic              CS_e,
    input  logic [CODE_W-1:0] codigo_e,
    output logic [N_REG-1:0]  escreve,
    output logic [MUX_W-1:0]  seleciona,
    output logic              RD,
    output logic              OE,
    output logic              CS,
    output logic [CODE_W-1:0] codigo,
    output logic              passo_ok,
    output logic              ocupado
);

    // The debounce counter is sized for the largest legal DEB_CYCLES (255).
    localparam int                CNT_W    = 8;
    localparam logic [CNT_W-1:0]  DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        APLICA = 2'd1,
        ESPERA = 2'd2
    } state_t;

    // Two-flop synchroniser stages for the raw button.
    logic             sync_p0;
    logic             sync_p1;

    // Debouncer state.
    logic [CNT_W-1:0] deb_cnt;
    logic             deb_level;
    logic             deb_level_d;
    logic             step_evt;

    // Step FSM and effective mode.
    state_t           state;
    logic             modo_ef;

    // Word captured at the step event; held on the outputs until the next step.
    logic [N_REG-1:0]  cap_escreve;
    logic [MUX_W-1:0]  cap_seleciona;
    logic              cap_rd;
    logic              cap_oe;
    logic              cap_cs;
    logic [CODE_W-1:0] cap_codigo;

    assign ocupado = (state != IDLE);

    // Bring the asynchronous button into the clock domain.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= passo_e;
            sync_p1 <= sync_p0;
        end
    end

    // Debounce: flip the level after DEB_CYCLES consecutive disagreeing samples,
    // and register its rising edge as the one-cycle step event.
    always_ff @(posedge clock) begin
        if (reset) begin
            deb_cnt     <= '0;
            deb_level   <= 1'b0;
            deb_level_d <= 1'b0;
            step_evt    <= 1'b0;
        end else begin
            deb_level_d <= deb_level;
            step_evt    <= deb_level & ~deb_level_d;
            if (sync_p1 != deb_level) begin
                if (deb_cnt == DEB_LAST) begin
                    deb_level <= ~deb_level;
                    deb_cnt   <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end else begin
                deb_cnt <= '0;
            end
        end
    end

    // Step FSM with registered control-word outputs. The word is driven at the
    // capture edge so that it is visible during the APLICA cycle together with
    // passo_ok; the mode only changes while IDLE so a step always completes in
    // the mode it started in.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            modo_ef       <= modo;
            escreve       <= '0;
            seleciona     <= '0;
            RD            <= 1'b0;
            OE            <= 1'b0;
            CS            <= 1'b0;
            codigo        <= '0;
            passo_ok      <= 1'b0;
            cap_escreve   <= '0;
            cap_seleciona <= '0;
            cap_rd        <= 1'b0;
            cap_oe        <= 1'b0;
            cap_cs        <= 1'b0;
            cap_codigo    <= '0;
        end else begin
            passo_ok <= 1'b0;
            if (state == IDLE) begin
                modo_ef <= modo;
            end
            case (state)
                IDLE: begin
                    if (!modo_ef) begin
                        escreve   <= escreve_e;
                        seleciona <= seleciona_e;
                        RD        <= RD_e;
                        OE        <= OE_e;
                        CS        <= CS_e;
                        codigo    <= codigo_e;
                    end else if (step_evt) begin
                        cap_escreve   <= escreve_e;
                        cap_seleciona <= seleciona_e;
                        cap_rd        <= RD_e;
                        cap_oe        <= OE_e;
                        cap_cs        <= CS_e;
                        cap_codigo    <= codigo_e;
                        escreve       <= escreve_e;
                        seleciona     <= seleciona_e;
                        RD            <= RD_e;
                        OE            <= OE_e;
                        CS            <= CS_e;
                        codigo        <= codigo_e;
                        passo_ok      <= 1'b1;
                        state         <= APLICA;
                    end else begin
                        escreve <= '0;
                    end
                end
                APLICA: begin
                    escreve <= '0;
                    state   <= ESPERA;
                end
                ESPERA: begin
                    escreve   <= '0;
                    seleciona <= cap_seleciona;
                    RD        <= cap_rd;
                    OE        <= cap_oe;
                    CS        <= cap_cs;
                    codigo    <= cap_codigo;
                    if (!deb_level) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    escreve <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_control_panel_io.sv
// Self-checking bench for control_panel_io: pass-through mode, stepped mode,
// debounce rejection, mode change mid-step, reset during APLICA, long press.
module tb_control_panel_io;

    localparam int N_REG  = 8;
    localparam int MUX_W  = 7;
    localparam int CODE_W = 3;
    localparam int DEB    = 4;

    typedef struct packed {
        logic [N_REG-1:0]  esc;
        logic [MUX_W-1:0]  sel;
        logic              rd;
        logic              oe;
        logic              cs;
        logic [CODE_W-1:0] cod;
    } word_t;

    localparam int WW = $bits(word_t);

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              modo = 1'b0;
    logic              passo_e = 1'b0;
    logic [N_REG-1:0]  escreve_e = '0;
    logic [MUX_W-1:0]  seleciona_e = '0;
    logic              RD_e = 1'b0;
    logic              OE_e = 1'b0;
    logic              CS_e = 1'b0;
    logic [CODE_W-1:0] codigo_e = '0;
    logic [N_REG-1:0]  escreve;
    logic [MUX_W-1:0]  seleciona;
    logic              RD;
    logic              OE;
    logic              CS;
    logic [CODE_W-1:0] codigo;
    logic              passo_ok;
    logic              ocupado;

    int    errors = 0;
    int    checks = 0;
    word_t sb[$];
    word_t held;

    control_panel_io #(
        .N_REG(N_REG), .MUX_W(MUX_W), .CODE_W(CODE_W), .DEB_CYCLES(DEB)
    ) dut (
        .clock(clock), .reset(reset), .modo(modo), .passo_e(passo_e),
        .escreve_e(escreve_e), .seleciona_e(seleciona_e),
        .RD_e(RD_e), .OE_e(OE_e), .CS_e(CS_e), .codigo_e(codigo_e),
        .escreve(escreve), .seleciona(seleciona), .RD(RD), .OE(OE), .CS(CS),
        .codigo(codigo), .passo_ok(passo_ok), .ocupado(ocupado)
    );

    always #5 clock = ~clock;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    function automatic word_t out_word();
        word_t w;
        w.esc = escreve; w.sel = seleciona; w.rd = RD; w.oe = OE; w.cs = CS; w.cod = codigo;
        return w;
    endfunction

    function automatic word_t no_write(input word_t w);
        word_t r;
        r = w;
        r.esc = '0;
        return r;
    endfunction

    function automatic word_t rand_word();
        word_t w;
        w = word_t'(WW'($urandom));
        w.esc = N_REG'($urandom_range(1, 255));
        return w;
    endfunction

    task automatic drive(input word_t w);
        escreve_e = w.esc; seleciona_e = w.sel; RD_e = w.rd; OE_e = w.oe; CS_e = w.cs; codigo_e = w.cod;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Ticks until passo_ok is seen (or budget expires); reports tick index and word.
    task automatic wait_pulse(input int budget, output int at, output word_t seen, output int early);
        at = -1; early = 0; seen = '0;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (passo_ok === 1'b1) begin
                at = i;
                seen = out_word();
                break;
            end
            if (escreve !== '0) early++;
        end
    endtask

    // Ticks until ocupado drops (or budget expires); reports tick index.
    task automatic wait_idle(input int budget, output int at);
        at = -1;
        for (int i = 1; i <= budget; i++) begin
            tick();
            if (ocupado === 1'b0) begin
                at = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        word_t w;
        reset = 1'b1; modo = 1'b0; passo_e = 1'b1;
        w = rand_word();
        drive(w);
        tick(); tick();
        checks++;
        if (out_word() !== word_t'(0)) begin
            errors++; $display("FAIL reset_outputs: got %h expected %h", out_word(), word_t'(0));
        end
        checks++;
        if (passo_ok !== 1'b0 || ocupado !== 1'b0) begin
            errors++; $display("FAIL reset_flags: got passo_ok=%b ocupado=%b expected 0 0", passo_ok, ocupado);
        end
        reset = 1'b0;
        passo_e = 1'b0;
        held = '0;
    endtask

    task automatic test_passthrough();
        word_t w, exp;
        passo_e = 1'b1;   // must be ignored in mode 0
        for (int i = 0; i < 12; i++) begin
            w = rand_word();
            if (i == 0) begin
                w.esc = 8'h05;
                w.cod = 3'b101;
            end
            drive(w);
            sb.push_back(w);
            tick();
            exp = sb.pop_front();
            checks++;
            if (out_word() !== exp) begin
                errors++; $display("FAIL passthrough[%0d]: got %h expected %h", i, out_word(), exp);
            end
            checks++;
            if (passo_ok !== 1'b0 || ocupado !== 1'b0) begin
                errors++; $display("FAIL passthrough_flags[%0d]: got passo_ok=%b ocupado=%b expected 0 0", i, passo_ok, ocupado);
            end
            held = w;
        end
        passo_e = 1'b0;
        repeat (10) tick();
    endtask

    task automatic test_step();
        word_t a, b, seen, exp;
        int at, early, rel;
        modo = 1'b1;
        tick(); tick();
        checks++;
        if (out_word() !== no_write(held)) begin
            errors++; $display("FAIL step_idle_hold: got %h expected %h", out_word(), no_write(held));
        end
        a = rand_word();
        a.esc = 8'h81;
        drive(a);
        passo_e = 1'b1;
        sb.push_back(a);
        wait_pulse(12, at, seen, early);
        exp = sb.pop_front();
        checks++;
        if (at !== DEB + 4) begin
            errors++; $display("FAIL step_latency: got tick %0d expected tick %0d", at, DEB + 4);
        end
        checks++;
        if (seen !== exp) begin
            errors++; $display("FAIL step_word: got %h expected %h", seen, exp);
        end
        checks++;
        if (early !== 0) begin
            errors++; $display("FAIL step_early_write: got %0d cycles expected 0", early);
        end
        b = rand_word();
        drive(b);
        tick();
        checks++;
        if (out_word() !== no_write(a) || passo_ok !== 1'b0 || ocupado !== 1'b1) begin
            errors++; $display("FAIL step_espera: got %h ok=%b busy=%b expected %h ok=0 busy=1", out_word(), passo_ok, ocupado, no_write(a));
        end
        passo_e = 1'b0;
        wait_idle(30, rel);
        checks++;
        if (rel !== DEB + 3) begin
            errors++; $display("FAIL step_release_latency: got tick %0d expected tick %0d", rel, DEB + 3);
        end
        checks++;
        if (out_word() !== no_write(a)) begin
            errors++; $display("FAIL step_after_release: got %h expected %h", out_word(), no_write(a));
        end
        held = a;
    endtask

    task automatic test_bounce();
        word_t c;
        int bad;
        c = rand_word();
        drive(c);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            passo_e = ((i / 2) % 2) != 0;
            tick();
            if (ocupado !== 1'b0 || passo_ok !== 1'b0 || out_word() !== no_write(held)) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL bounce: got %0d disturbed cycles expected 0", bad);
        end
        passo_e = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_mode_change();
        word_t d, e, f, seen, exp;
        int at, early, rel, bad;
        d = rand_word();
        drive(d);
        passo_e = 1'b1;
        sb.push_back(d);
        wait_pulse(12, at, seen, early);
        exp = sb.pop_front();
        checks++;
        if (at !== DEB + 4 || seen !== exp) begin
            errors++; $display("FAIL mode_step: got tick %0d word %h expected tick %0d word %h", at, seen, DEB + 4, exp);
        end
        modo = 1'b0;
        e = rand_word();
        drive(e);
        bad = 0;
        repeat (5) begin
            tick();
            if (out_word() !== no_write(d) || ocupado !== 1'b1) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++; $display("FAIL mode_retained: got %0d cycles not holding step word expected 0", bad);
        end
        passo_e = 1'b0;
        wait_idle(30, rel);
        checks++;
        if (rel < 0 || out_word() !== no_write(d)) begin
            errors++; $display("FAIL mode_idle: got tick %0d word %h expected word %h", rel, out_word(), no_write(d));
        end
        tick();
        checks++;
        if (out_word() !== no_write(d)) begin
            errors++; $display("FAIL mode_switch_cycle: got %h expected %h", out_word(), no_write(d));
        end
        tick();
        checks++;
        if (out_word() !== e) begin
            errors++; $display("FAIL mode_passthrough_start: got %h expected %h", out_word(), e);
        end
        f = rand_word();
        drive(f);
        sb.push_back(f);
        tick();
        exp = sb.pop_front();
        checks++;
        if (out_word() !== exp) begin
            errors++; $display("FAIL mode_passthrough: got %h expected %h", out_word(), exp);
        end
        held = f;
    endtask

    task automatic test_reset_aplica();
        word_t g, seen;
        int at, early;
        modo = 1'b1;
        tick(); tick();
        g = rand_word();
        drive(g);
        passo_e = 1'b1;
        wait_pulse(12, at, seen, early);
        checks++;
        if (at < 0 || seen !== g) begin
            errors++; $display("FAIL reset_aplica_step: got tick %0d word %h expected word %h", at, seen, g);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (out_word() !== word_t'(0) || ocupado !== 1'b0 || passo_ok !== 1'b0) begin
            errors++; $display("FAIL reset_aplica: got %h busy=%b ok=%b expected 0 busy=0 ok=0", out_word(), ocupado, passo_ok);
        end
        reset = 1'b0;
        passo_e = 1'b0;
        tick();
        checks++;
        if (out_word() !== word_t'(0) || ocupado !== 1'b0) begin
            errors++; $display("FAIL reset_aplica_after: got %h busy=%b expected 0 busy=0", out_word(), ocupado);
        end
        repeat (8) tick();
        held = '0;
    endtask

    task automatic test_long_press();
        word_t h, seen, exp;
        int pulses, esc_cyc, rel;
        h = rand_word();
        drive(h);
        passo_e = 1'b1;
        sb.push_back(h);
        pulses = 0; esc_cyc = 0; seen = '0;
        for (int i = 1; i <= 50; i++) begin
            tick();
            if (passo_ok === 1'b1) begin
                pulses++;
                seen = out_word();
            end
            if (escreve !== '0) esc_cyc++;
        end
        exp = sb.pop_front();
        checks++;
        if (pulses !== 1 || esc_cyc !== 1) begin
            errors++; $display("FAIL long_press_pulses: got ok=%0d write=%0d expected 1 1", pulses, esc_cyc);
        end
        checks++;
        if (seen !== exp) begin
            errors++; $display("FAIL long_press_word: got %h expected %h", seen, exp);
        end
        checks++;
        if (ocupado !== 1'b1) begin
            errors++; $display("FAIL long_press_busy: got %b expected 1", ocupado);
        end
        passo_e = 1'b0;
        wait_idle(30, rel);
        checks++;
        if (rel !== DEB + 3) begin
            errors++; $display("FAIL long_press_release: got tick %0d expected tick %0d", rel, DEB + 3);
        end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_step();
        test_bounce();
        test_mode_change();
        test_reset_aplica();
        test_long_press();
        checks++;
        if (sb.size() !== 0) begin
            errors++; $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/control_panel_io.md
CONTROL_PANEL_IO -- requirements
Module: control_panel_io

Interface
REQ-001 SHALL have parameter N_REG, default 8, number of register write-enable channels (R1..R6, RDM, REM).
REQ-002 SHALL have parameter MUX_W, default 7, packed width of all mux-select fields.
REQ-003 SHALL have parameter CODE_W, default 3, ALU operation code width.
REQ-004 SHALL have parameter DEB_CYCLES, default 4, range 1..255, debounce stability length in clocks.
REQ-005 SHALL have port clock  in  1  sole clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  in  1  synchronous reset, active-high.
REQ-007 SHALL have port modo  in  1  0 = registered pass-through, 1 = single-step.
REQ-008 SHALL have port passo_e  in  1  raw asynchronous step button.
REQ-009 SHALL have port escreve_e  in  N_REG  requested write enables.
REQ-010 SHALL have port seleciona_e  in  MUX_W  requested mux selects.
REQ-011 SHALL have ports RD_e, OE_e, CS_e  in  1 each  requested memory controls.
REQ-012 SHALL have port codigo_e  in  CODE_W  requested ALU code.
REQ-013 SHALL have ports escreve (out, N_REG), seleciona (out, MUX_W), RD, OE, CS (out, 1 each) and codigo (out, CODE_W), the applied control word; all registered.
REQ-014 SHALL have port passo_ok  out  1  one-cycle pulse marking the cycle a stepped word is applied.
REQ-015 SHALL have port ocupado  out  1  high whenever the step FSM is not IDLE.

Function
REQ-016 SHALL synchronise passo_e through two flip-flops before any other use.
REQ-017 SHALL keep a debounced level; it toggles only after the synchronised value has differed from it for DEB_CYCLES consecutive cycles; any agreeing cycle clears the counter.
REQ-018 SHALL form the step event as the rising edge of the debounced level (one cycle wide).
REQ-019 SHALL hold an effective mode register, loaded from modo only while the FSM is IDLE; a modo change mid-step takes effect on return to IDLE.
REQ-020 Mode 0: every output SHALL equal the corresponding input sampled one cycle earlier (latency 1); passo_ok = 0; FSM stays IDLE; step events are ignored.
REQ-021 Mode 1 FSM SHALL have states IDLE, APLICA and ESPERA.
REQ-022 IDLE: escreve = 0; seleciona, RD, OE, CS and codigo hold their last values; on a step event, SHALL capture all *_e inputs and enter APLICA next cycle.
REQ-023 APLICA: lasts exactly one cycle; outputs = captured word, escreve included; passo_ok = 1; SHALL then enter ESPERA.
REQ-024 ESPERA: escreve = 0, other outputs hold the captured word; SHALL return to IDLE once the debounced level is 0.
REQ-025 Input changes outside the capture cycle SHALL NOT affect outputs in mode 1.
REQ-026 Write enables SHALL never be asserted for more than one cycle per step event.
REQ-027 Total step latency, given a clean stable press: the escreve pulse SHALL appear exactly 2 + DEB_CYCLES + 1 cycles after the first clock edge sampling passo_e high.

Reset
REQ-028 While reset is high, all outputs, the synchroniser, the debounce counter and level, and the capture register SHALL be 0; the FSM SHALL be IDLE; the mode register SHALL load modo.
REQ-029 Reset SHALL override everything, including a step in APLICA (pulse aborted; escreve = 0 on the next cycle).

Verification
REQ-030 Mode 0, escreve_e=8'h05, codigo_e=3'b101 -> escreve=8'h05, codigo=3'b101 one cycle later; passo_ok stays 0.
REQ-031 Mode 1, DEB_CYCLES=4, escreve_e=8'h81, stable press -> escreve=8'h81 for exactly one cycle, 7 cycles after the first high sample; passo_ok coincident; escreve=8'h00 afterwards.
REQ-032 Mode 1, passo_e toggling every 2 cycles (bounce) -> no step event, outputs unchanged, ocupado=0.
REQ-033 Mode 1, modo driven to 0 while in ESPERA -> mode 1 behaviour retained until release; pass-through starts the cycle after IDLE.
REQ-034 Reset asserted during APLICA -> next cycle all outputs 0, FSM IDLE, ocupado=0.
REQ-035 Mode 1, press held 50 cycles -> exactly one escreve pulse; ocupado high until release has been debounced.
